// File: rtl/mult_div_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// FSM state encodings and the default datapath width.
package mult_div_pkg;

  localparam int N_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_MULT  = 3'b001,
    OP_MULTU = 3'b010,
    OP_DIV   = 3'b011,
    OP_DIVU  = 3'b100,
    OP_MTHI  = 3'b101,
    OP_MTLO  = 3'b110,
    OP_RSVD  = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } state_t;

  // True for the ops that run the iterative engine.
  function automatic logic is_iter_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_core.sv
// Unsigned iterative engine: N steps of shift-add multiply or restoring
// shift-subtract divide on magnitudes loaded by the parent.
// Multiply: {acc, sr} ends as the 2N-bit product.
// Divide:   acc ends as the remainder, sr as the quotient.
module mdu_core
  import mult_div_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         run,
  input  logic         is_div,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         last,
  output logic [N-1:0] acc_out,
  output logic [N-1:0] sr_out
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [CW-1:0] cnt;
  logic [N-1:0]  acc;
  logic [N-1:0]  sr;
  logic [N-1:0]  b_q;
  logic          div_q;
  logic [N:0]    sum;
  logic [N:0]    shifted;
  logic [N:0]    diff;

  // Step datapath: add for multiply, trial subtract for divide.
  always_comb begin
    sum     = {1'b0, acc} + (sr[0] ? {1'b0, b_q} : {(N+1){1'b0}});
    shifted = {acc, sr[N-1]};
    diff    = shifted - {1'b0, b_q};
  end

  // Engine registers: load operands, then one step per run cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      sr    <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      acc   <= '0;
      sr    <= a;
      b_q   <= b;
      div_q <= is_div;
      cnt   <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
      if (div_q) begin
        if (!diff[N]) begin
          acc <= diff[N-1:0];
          sr  <= {sr[N-2:0], 1'b1};
        end else begin
          acc <= shifted[N-1:0];
          sr  <= {sr[N-2:0], 1'b0};
        end
      end else begin
        acc <= sum[N:1];
        sr  <= {sum[0], sr[N-1:1]};
      end
    end
  end

  assign last    = (cnt == CW'(N - 1));
  assign acc_out = acc;
  assign sr_out  = sr;

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: control FSM, signed-to-magnitude handling,
// result sign correction and the architectural HI/LO registers.
// Handshake: an op is taken when start=1 while busy=0 and op is
// MULT/MULTU/DIV/DIVU; busy stays high until the result is written, and
// done pulses for one cycle once HI/LO hold the new result. MTHI/MTLO
// write in the same edge without raising busy or done.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [N-1:0] rs_data,
  input  logic [N-1:0] rt_data,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output state_t       dbg_state
);

  state_t         state;
  state_t         state_nxt;
  logic           accept;
  logic           mt_write;
  logic           core_load;
  logic           core_run;
  logic           core_last;
  logic           fix_write;
  logic           signed_op;
  logic           div_op;
  logic           rs_neg;
  logic           rt_neg;
  logic [N-1:0]   a_mag;
  logic [N-1:0]   b_mag;
  logic           is_div_q;
  logic           neg_q;
  logic           neg_r;
  logic           dbz_q;
  logic [N-1:0]   rs_q;
  logic [N-1:0]   core_hi;
  logic [N-1:0]   core_lo;
  logic [2*N-1:0] prod_fix;
  logic [N-1:0]   quo_fix;
  logic [N-1:0]   rem_fix;
  logic [N-1:0]   hi_nxt;
  logic [N-1:0]   lo_nxt;

  assign accept    = (state == ST_IDLE) && start && is_iter_op(op);
  assign mt_write  = (state == ST_IDLE) && start && ((op == OP_MTHI) || (op == OP_MTLO));
  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign div_op    = (op == OP_DIV) || (op == OP_DIVU);
  assign rs_neg    = signed_op && rs_data[N-1];
  assign rt_neg    = signed_op && rt_data[N-1];
  assign a_mag     = rs_neg ? (~rs_data + 1'b1) : rs_data;
  assign b_mag     = rt_neg ? (~rt_data + 1'b1) : rt_data;

  mdu_core #(.N(N)) u_core (
    .clk     (clk),
    .reset   (reset),
    .load    (core_load),
    .run     (core_run),
    .is_div  (div_op),
    .a       (a_mag),
    .b       (b_mag),
    .last    (core_last),
    .acc_out (core_hi),
    .sr_out  (core_lo)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // FSM next state and engine controls.
  always_comb begin
    state_nxt = state;
    core_load = 1'b0;
    core_run  = 1'b0;
    fix_write = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          core_load = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        core_run = 1'b1;
        if (core_last) state_nxt = ST_FIX;
      end
      ST_FIX: begin
        fix_write = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Capture result signs and divide-by-zero at acceptance; the raw
  // dividend is kept because a zero divisor returns it unchanged in HI.
  always_ff @(posedge clk) begin
    if (reset) begin
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dbz_q    <= 1'b0;
      rs_q     <= '0;
    end else if (core_load) begin
      is_div_q <= div_op;
      neg_q    <= rs_neg ^ rt_neg;
      neg_r    <= div_op && rs_neg;
      dbz_q    <= div_op && (rt_data == '0);
      rs_q     <= rs_data;
    end
  end

  // Sign correction of the unsigned engine result.
  always_comb begin
    prod_fix = neg_q ? (~{core_hi, core_lo} + 1'b1) : {core_hi, core_lo};
    quo_fix  = neg_q ? (~core_lo + 1'b1) : core_lo;
    rem_fix  = neg_r ? (~core_hi + 1'b1) : core_hi;
    if (dbz_q) begin
      hi_nxt = rs_q;
      lo_nxt = '1;
    end else if (is_div_q) begin
      hi_nxt = rem_fix;
      lo_nxt = quo_fix;
    end else begin
      hi_nxt = prod_fix[2*N-1:N];
      lo_nxt = prod_fix[N-1:0];
    end
  end

  // HI/LO registers and the completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= fix_write;
      if (fix_write) begin
        hi <= hi_nxt;
        lo <= lo_nxt;
      end else if (mt_write) begin
        if (op == OP_MTHI) hi <= rs_data;
        else               lo <= rs_data;
      end
    end
  end

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit with hand-computed HI/LO results.
module tb_mult_div_unit;
  import mult_div_pkg::*;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [N-1:0] rs_data;
  logic [N-1:0] rt_data;
  logic         busy;
  logic         done;
  logic [N-1:0] hi;
  logic [N-1:0] lo;
  state_t       dbg_state;

  int checks = 0;
  int errors = 0;
  logic [2*N-1:0] exp_q[$];

  mult_div_unit #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one start cycle; returns at the falling edge after edge 0.
  task automatic issue(input logic [2:0] o, input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    op    = OP_NOP;
  endtask

  // Wait (bounded) for done, counting busy cycles and watching HI/LO hold.
  // A second MULTU 2x2 start is driven into edge inject_at when inject_at>=0.
  task automatic wait_done(input int inject_at, output int done_edge,
                           output int busy_cycles, output logic hold_bad);
    logic [N-1:0] hi0;
    logic [N-1:0] lo0;
    hi0 = hi;
    lo0 = lo;
    done_edge   = -1;
    busy_cycles = 0;
    hold_bad    = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (done) begin
        done_edge = k;
        break;
      end
      if (busy) busy_cycles++;
      if (hi !== hi0 || lo !== lo0) hold_bad = 1'b1;
      if (k + 1 == inject_at) begin
        start = 1'b1; op = OP_MULTU; rs_data = 32'd2; rt_data = 32'd2;
      end else begin
        start = 1'b0; op = OP_NOP;
      end
      @(posedge clk);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic run_vec(input string tag, input logic [2:0] o,
                         input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] exp_hi, input logic [N-1:0] exp_lo,
                         input int inject_at);
    int done_edge;
    int busy_cycles;
    logic hold_bad;
    logic [2*N-1:0] exp;
    exp_q.push_back({exp_hi, exp_lo});
    issue(o, a, b);
    wait_done(inject_at, done_edge, busy_cycles, hold_bad);
    exp = exp_q.pop_front();
    check({tag, "_done_edge"}, done_edge, N + 1);
    check({tag, "_busy_cycles"}, busy_cycles, N + 1);
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_hold"}, {31'd0, hold_bad}, 32'd0);
    check({tag, "_hi"}, hi, exp[2*N-1:N]);
    check({tag, "_lo"}, lo, exp[N-1:0]);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic seen;
    reset   = 1'b1;
    start   = 1'b0;
    op      = OP_NOP;
    rs_data = '0;
    rt_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});

    run_vec("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, -1);
    run_vec("mult_m3x5", OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, -1);
    run_vec("div_m7d2",  OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);
    run_vec("divu_dz",   OP_DIVU,  32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF, -1);
    run_vec("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, -1);
    run_vec("multu_7x6", OP_MULTU, 32'd7,         32'd6,         32'h0000_0000, 32'h0000_002A, -1);
    run_vec("divu_100_7",OP_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, -1);
    run_vec("div_7dm2",  OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, -1);
    run_vec("mult_minsq",OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, -1);
    run_vec("div_sdz",   OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, -1);
    // Second start lands on edge 5 while busy and must be dropped.
    run_vec("mult_inject", OP_MULT, 32'd6,        32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 5);

    // Reset on RUN cycle 10 aborts a DIVU.
    issue(OP_DIVU, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("abort_no_done", {31'd0, seen}, 32'd0);

    // MTLO / MTHI write in a single edge with no busy or done.
    issue(OP_MTLO, 32'h0000_1234, 32'd0);
    check("mtlo_lo", lo, 32'h0000_1234);
    check("mtlo_hi", hi, 32'd0);
    check("mtlo_busy", {31'd0, busy}, 32'd0);
    check("mtlo_done", {31'd0, done}, 32'd0);
    issue(OP_MTHI, 32'h0000_ABCD, 32'd0);
    check("mthi_hi", hi, 32'h0000_ABCD);
    check("mthi_lo", lo, 32'h0000_1234);
    check("mthi_busy", {31'd0, busy}, 32'd0);

    // NOP and reserved ops are ignored.
    issue(OP_NOP, 32'hDEAD_BEEF, 32'd3);
    check("nop_busy", {31'd0, busy}, 32'd0);
    issue(OP_RSVD, 32'hDEAD_BEEF, 32'd3);
    check("rsvd_busy", {31'd0, busy}, 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("ignored_quiet", {31'd0, seen}, 32'd0);
    check("ignored_hi", hi, 32'h0000_ABCD);
    check("ignored_lo", lo, 32'h0000_1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
